// File: rtl/mem_burst_ctrl_if.sv
// Cache-side and memory-side signal bundle for mem_burst_ctrl.
// master = the burst controller, slave = the cache/memory environment.
interface mem_burst_ctrl_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic        req_ready;
    logic [3:0]  wb_word_idx;
    logic [31:0] wb_data;
    logic        fill_valid;
    logic [3:0]  fill_idx;
    logic [31:0] fill_data;
    logic        done;
    logic        error;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_write;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, wb_data,
               mem_cmd_ready, mem_rvalid, mem_rdata,
        output req_ready, wb_word_idx, fill_valid, fill_idx, fill_data,
               done, error, mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, wb_data,
               mem_cmd_ready, mem_rvalid, mem_rdata,
        input  req_ready, wb_word_idx, fill_valid, fill_idx, fill_data,
               done, error, mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wdata
    );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Cache-line burst controller: write-back (evict) and line-fill bursts to word memory.
// Define MEM_TIMEOUT_EN to add a watchdog that aborts a stalled burst with done+error.
module mem_burst_ctrl #(
    parameter int unsigned LINE_WORDS  = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input logic              clk,
    input logic              rst_b,
    mem_burst_ctrl_if.master bus
);
    localparam int unsigned IW = $clog2(LINE_WORDS);
    localparam int unsigned CW = IW + 1;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t        state;
    logic [25:0]   line_q;
    logic [CW-1:0] cmd_cnt;
    logic [CW-1:0] rsp_cnt;

    logic       cmd_valid;
    logic       cmd_fire;
    logic       rsp_fire;
    logic       last_cmd;
    logic       last_rsp;
    logic [3:0] cmd_idx;
    logic [3:0] rsp_idx;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[5:0];

    assign cmd_idx   = 4'(cmd_cnt[IW-1:0]);
    assign rsp_idx   = 4'(rsp_cnt[IW-1:0]);
    assign cmd_valid = (state == WB) || ((state == FILL) && (cmd_cnt < CW'(LINE_WORDS)));
    assign cmd_fire  = cmd_valid && bus.mem_cmd_ready;
    // Responses beyond the issued commands are stray and dropped.
    assign rsp_fire  = (state == FILL) && bus.mem_rvalid && (rsp_cnt < cmd_cnt);
    assign last_cmd  = (cmd_cnt == CW'(LINE_WORDS - 1));
    assign last_rsp  = (rsp_cnt == CW'(LINE_WORDS - 1));

    assign bus.req_ready     = (state == IDLE);
    assign bus.mem_cmd_valid = cmd_valid;
    assign bus.mem_cmd_write = (state == WB);
    // Word index is spliced into the aligned line, so the address cannot carry out of it.
    assign bus.mem_cmd_addr  = cmd_valid ? {line_q, cmd_idx, 2'b00} : '0;
    assign bus.mem_wdata     = (state == WB) ? bus.wb_data : '0;
    assign bus.wb_word_idx   = (state == WB) ? cmd_idx : '0;
    assign bus.fill_valid    = rsp_fire;
    assign bus.fill_idx      = rsp_fire ? rsp_idx : '0;
    assign bus.fill_data     = rsp_fire ? bus.mem_rdata : '0;
    assign bus.done          = (state == DONE);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    logic [WW-1:0] wd_cnt;
    logic          err_q;

    assign bus.error = (state == DONE) && err_q;
`else
    assign bus.error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            line_q  <= '0;
            cmd_cnt <= '0;
            rsp_cnt <= '0;
`ifdef MEM_TIMEOUT_EN
            wd_cnt  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        line_q  <= bus.req_addr[31:6];
                        cmd_cnt <= '0;
                        rsp_cnt <= '0;
                        state   <= bus.req_write ? WB : FILL;
`ifdef MEM_TIMEOUT_EN
                        wd_cnt  <= '0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                WB: begin
                    if (cmd_fire) begin
                        cmd_cnt <= cmd_cnt + CW'(1);
                        if (last_cmd) state <= DONE;
                    end
                end
                FILL: begin
                    if (cmd_fire) cmd_cnt <= cmd_cnt + CW'(1);
                    if (rsp_fire) begin
                        rsp_cnt <= rsp_cnt + CW'(1);
                        if (last_rsp) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef MEM_TIMEOUT_EN
            // Any handshake or response restarts the stall count.
            if ((state == WB) || (state == FILL)) begin
                if (cmd_fire || rsp_fire) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == WW'(TIMEOUT_CYC - 1)) begin
                    state <= DONE;
                    err_q <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + WW'(1);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl: directed bursts, expected traffic queued at issue,
// a negedge monitor pops and compares every command, fill strobe and done pulse.
module tb_mem_burst_ctrl;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    mem_burst_ctrl_if bus();

    mem_burst_ctrl #(.LINE_WORDS(16), .TIMEOUT_CYC(255)) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    // Cache data array model: word i of the evicted line holds 0xB0+i.
    assign bus.wb_data = 32'hB0 + 32'(bus.wb_word_idx);

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [35:0] exp_fill[$];
    logic        exp_done[$];

    int n_chk  = 0;
    int n_fail = 0;

    int  mode = 0;
    logic tog = 1'b0;
    logic s_done, s_acc, s_fill;
    logic [3:0] s_fill_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        cmd_t        c;
        logic [35:0] f;
        logic        e;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
                    if (exp_cmd.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_cmd: got addr %0h, expected no command", bus.mem_cmd_addr);
                    end else begin
                        c = exp_cmd.pop_front();
                        check("cmd_addr", 64'(bus.mem_cmd_addr), 64'(c.addr));
                        check("cmd_write", 64'(bus.mem_cmd_write), 64'(c.wr));
                        if (c.wr) check("cmd_wdata", 64'(bus.mem_wdata), 64'(c.data));
                    end
                end
                if (bus.fill_valid) begin
                    if (exp_fill.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_fill: got idx %0h, expected no strobe", bus.fill_idx);
                    end else begin
                        f = exp_fill.pop_front();
                        check("fill_idx", 64'(bus.fill_idx), 64'(f[35:32]));
                        check("fill_data", 64'(bus.fill_data), 64'(f[31:0]));
                    end
                end else begin
                    check("fill_unqualified", {28'h0, bus.fill_idx, bus.fill_data}, 64'h0);
                end
                if (bus.done) begin
                    if (exp_done.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected 0");
                    end else begin
                        e = exp_done.pop_front();
                        check("done_error", 64'(bus.error), 64'(e));
                    end
                end else begin
                    check("error_without_done", 64'(bus.error), 64'h0);
                end
            end
        end
    end

    // One clock: sample at negedge, then drive memory inputs at posedge+1.
    task automatic tick();
        logic        hs_rd;
        logic [31:0] a;
        @(negedge clk);
        hs_rd      = bus.mem_cmd_valid && bus.mem_cmd_ready && !bus.mem_cmd_write;
        a          = bus.mem_cmd_addr;
        s_done     = bus.done;
        s_acc      = bus.req_valid && bus.req_ready;
        s_fill     = bus.fill_valid;
        s_fill_idx = bus.fill_idx;
        @(posedge clk);
        #1;
        bus.mem_rvalid = hs_rd;
        bus.mem_rdata  = hs_rd ? (32'hA000_0000 + 32'(a[5:2])) : 32'h0;
        case (mode)
            0: bus.mem_cmd_ready = 1'b1;
            1: begin bus.mem_cmd_ready = tog; tog = ~tog; end
            default: bus.mem_cmd_ready = 1'b0;
        endcase
    endtask

    task automatic push_fill(input logic [31:0] line);
        for (int i = 0; i < 16; i++) begin
            exp_cmd.push_back(cmd_t'{addr: line + 32'(4 * i), wr: 1'b0, data: 32'h0});
            exp_fill.push_back({4'(i), 32'hA000_0000 + 32'(i)});
        end
        exp_done.push_back(1'b0);
    endtask

    task automatic push_wb(input logic [31:0] line);
        for (int i = 0; i < 16; i++)
            exp_cmd.push_back(cmd_t'{addr: line + 32'(4 * i), wr: 1'b1, data: 32'hB0 + 32'(i)});
        exp_done.push_back(1'b0);
    endtask

    // Issue one request in the current cycle (cycle 0); lat = cycle index of done, -1 if none.
    task automatic run_req(input logic wr, input logic [31:0] addr, input int budget,
                           input bit spur, output int lat);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        lat = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (n == 0) begin
                check("req_accept", 64'(s_acc), 64'h1);
                bus.req_valid = 1'b0;
                bus.req_write = 1'b0;
                bus.req_addr  = 32'h0;
                if (spur) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = 32'hDEAD_BEEF;
                end
            end
            if (s_done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, acc, dn, a2, d1, d2, seen;
        bus.req_valid     = 1'b0;
        bus.req_write     = 1'b0;
        bus.req_addr      = 32'h0;
        bus.mem_cmd_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'h1);
        check("rst_cmd", {31'h0, bus.mem_cmd_valid, bus.mem_cmd_addr}, 64'h0);
        check("rst_outs", {56'h0, bus.done, bus.error, bus.fill_valid, bus.mem_cmd_write, bus.wb_word_idx}, 64'h0);
        rst_b = 1'b1;
        tick(); tick();

        // Fill, ready always high, response one cycle after each command
        mode = 0;
        push_fill(32'h0000_1040);
        run_req(1'b0, 32'h0000_1044, 60, 1'b0, lat);
        check("fill_done_latency", 64'(lat), 64'(18));
        check("idle_after_done", 64'(bus.req_ready), 64'h1);

        // Write-back with ready toggling 1/0
        mode = 1; tog = 1'b1;
        push_wb(32'h0000_0040);
        run_req(1'b1, 32'h0000_0040, 60, 1'b0, lat);
        check("wb_toggle_latency", 64'(lat), 64'(32));

        // Fill with toggling ready and a stray response before any command
        mode = 1; tog = 1'b1;
        push_fill(32'h0000_20C0);
        run_req(1'b0, 32'h0000_20FF, 80, 1'b1, lat);
        check("fill_toggle_latency", 64'(lat), 64'(33));

        // Response strobe in IDLE is ignored
        mode = 0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        check("idle_rvalid_ignored", {62'h0, bus.fill_valid, bus.done}, 64'h0);
        tick();

        // Reset pulse after fill word 5
        push_fill(32'h0000_3000);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_3000;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (n == 0) bus.req_valid = 1'b0;
            if (s_fill && s_fill_idx == 4'd5) begin seen = 1; break; end
        end
        check("fill5_seen", 64'(seen), 64'h1);
        rst_b = 1'b0;
        #1;
        check("midrst_req_ready", 64'(bus.req_ready), 64'h1);
        check("midrst_cmd", {31'h0, bus.mem_cmd_valid, bus.mem_cmd_addr}, 64'h0);
        check("midrst_fill", {27'h0, bus.fill_valid, bus.fill_idx, bus.fill_data}, 64'h0);
        check("midrst_done", {62'h0, bus.done, bus.error}, 64'h0);
        exp_cmd.delete(); exp_fill.delete(); exp_done.delete();
        bus.mem_rvalid = 1'b0;
        tick(); tick();
        rst_b = 1'b1;
        tick(); tick(); tick();
        push_wb(32'h0000_3000);
        run_req(1'b1, 32'h0000_3000, 40, 1'b0, lat);
        check("post_rst_wb_latency", 64'(lat), 64'(17));

        // req_valid held through a write-back: second accept only after done
        push_wb(32'h0000_0080);
        push_wb(32'h0000_00C0);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0000_0080;
        acc = 0; dn = 0; a2 = -1; d1 = -1; d2 = -1;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (s_acc) begin
                if (acc == 0) bus.req_addr = 32'h0000_00C0;
                else begin a2 = n; bus.req_valid = 1'b0; end
                acc++;
            end
            if (s_done) begin
                if (dn == 0) d1 = n; else d2 = n;
                dn++;
            end
            if (dn == 2) break;
        end
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0;
        check("held_first_done", 64'(d1), 64'(17));
        check("held_second_accept", 64'(a2), 64'(18));
        check("held_second_done", 64'(d2), 64'(35));
        check("held_accept_count", 64'(acc), 64'(2));

        // Memory never ready
        mode = 2;
`ifdef MEM_TIMEOUT_EN
        exp_done.push_back(1'b1);
        run_req(1'b1, 32'h0000_0100, 300, 1'b0, lat);
        check("timeout_latency", 64'(lat), 64'(256));
        check("timeout_back_idle", 64'(bus.req_ready), 64'h1);
`else
        run_req(1'b1, 32'h0000_0100, 300, 1'b0, lat);
        check("no_watchdog_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        check("stuck_in_wb", {27'h0, bus.mem_cmd_valid, bus.wb_word_idx, bus.mem_cmd_addr}, {27'h0, 1'b1, 4'h0, 32'h0000_0100});
        check("stuck_error", 64'(bus.error), 64'h0);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
`endif
        mode = 0;
        tick(); tick(); tick();
        check("exp_cmd_left", 64'(exp_cmd.size()), 64'h0);
        check("exp_fill_left", 64'(exp_fill.size()), 64'h0);
        check("exp_done_left", 64'(exp_done.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
